// File: rtl/fft_stage_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_pkg                                                              |
// | Shared types, constants and address helper for the FFT sequencer.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fft_pkg;

    localparam int FFT_POINTS = 1024;
    localparam int WORDS      = 256;
    localparam int LANES      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Spread c around a zero at bit 'pos': bits below pos stay, bits above shift up.
    function automatic logic [7:0] insert_zero_bit(input logic [6:0] c, input logic [2:0] pos);
        logic [7:0] ext;
        logic [7:0] mask;
        ext  = {1'b0, c};
        mask = (8'd1 << pos) - 8'd1;
        return ((ext & ~mask) << 1) | (ext & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_stage_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_stage_sequencer_if                                               |
// | Control and issue bundle between CSR logic, sequencer and datapath.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fft_stage_sequencer_if;
    logic       i_start;
    logic       i_stall;
    logic       o_busy;
    logic       o_done;
    logic [3:0] o_stage;
    logic [7:0] o_addr1;
    logic [7:0] o_addr2;
    logic       o_valid;
    logic [9:0] o_stride;
    logic [8:0] o_twiddle_offset1;
    logic [8:0] o_twiddle_offset2;
    logic [8:0] o_twiddle_offset3;
    logic [8:0] o_twiddle_offset4;

    modport master (
        output i_start, i_stall,
        input  o_busy, o_done, o_stage, o_addr1, o_addr2, o_valid, o_stride,
        input  o_twiddle_offset1, o_twiddle_offset2, o_twiddle_offset3, o_twiddle_offset4
    );

    modport slave (
        input  i_start, i_stall,
        output o_busy, o_done, o_stage, o_addr1, o_addr2, o_valid, o_stride,
        output o_twiddle_offset1, o_twiddle_offset2, o_twiddle_offset3, o_twiddle_offset4
    );
endinterface
`default_nettype wire

// File: rtl/fft_stage_sequencer_twiddle_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_twiddle_gen                                                      |
// | Combinational twiddle ROM index for the four butterflies of an issue.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fft_twiddle_gen
    import fft_pkg::*;
(
    input  wire logic [6:0]             c,
    input  wire logic [3:0]             stage,
    output logic      [LANES-1:0][8:0]  offsets
);

    logic [2:0]  w_word_shift;
    logic [7:0]  w_word_mask;
    logic [7:0]  w_c_low;
    logic [1:0]  w_lane;
    logic [16:0] w_scaled;

    // Stride >= 4: t mod stride = 4*(c mod sw) + lane, scaled by 512/stride = 2^stage.
    always_comb begin
        offsets      = '0;
        w_lane       = 2'd0;
        w_scaled     = '0;
        w_word_shift = 3'd7 - stage[2:0];
        w_word_mask  = (stage <= 4'd7) ? ((8'd1 << w_word_shift) - 8'd1) : 8'd0;
        w_c_low      = {1'b0, c} & w_word_mask;
        for (int l = 0; l < LANES; l++) begin
            w_lane   = 2'(l);
            w_scaled = 17'({w_c_low, w_lane}) << stage;
            if (stage <= 4'd7) begin
                offsets[l] = w_scaled[8:0];
            end else if (stage == 4'd8) begin
                offsets[l] = w_lane[0] ? 9'd256 : 9'd0;
            end else begin
                offsets[l] = 9'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_stage_sequencer                                                  |
// | Walks all stages of a 1024-point in-place FFT, draining between them.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int NUM_STAGES       = 10,
    parameter int ISSUES_PER_STAGE = 128,
    parameter int PIPE_DELAY       = 5,
    parameter int DRAIN_CYCLES     = PIPE_DELAY + 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fft_stage_sequencer_if.slave bus
);

    localparam logic [6:0] c_last_issue = 7'(ISSUES_PER_STAGE - 1);
    localparam logic [3:0] c_last_stage = 4'(NUM_STAGES - 1);
    localparam logic [3:0] c_drain_last = 4'(DRAIN_CYCLES);

    state_t     r_state;
    logic [3:0] r_stage;
    logic [6:0] r_c;
    logic [3:0] r_drain;
    logic       r_busy;
    logic       r_done;
    logic       r_valid;
    logic [7:0] r_addr1;
    logic [7:0] r_addr2;
    logic [9:0] r_stride;
    logic [LANES-1:0][8:0] r_tw;

    logic       w_emit;
    logic [3:0] w_iss_stage;
    logic [6:0] w_iss_c;
    logic [9:0] w_stride;
    logic [7:0] w_addr1;
    logic [7:0] w_addr2;
    logic [LANES-1:0][8:0] w_tw;

    // Outputs are registered, so decode the issue that will be visible next cycle.
    always_comb begin
        w_iss_stage = r_stage;
        w_iss_c     = r_c;
        case (r_state)
            ST_IDLE: begin
                w_iss_stage = 4'd0;
                w_iss_c     = 7'd0;
            end
            ST_DRAIN: begin
                w_iss_stage = r_stage + 4'd1;
                w_iss_c     = 7'd0;
            end
            default: ;
        endcase

        w_emit = ((r_state == ST_IDLE)  && bus.i_start) ||
                 ((r_state == ST_ISSUE) && !bus.i_stall) ||
                 ((r_state == ST_DRAIN) && (r_drain == c_drain_last) && (r_stage != c_last_stage));

        w_stride = 10'd512 >> w_iss_stage;
        if (w_iss_stage >= 4'd8) begin
            w_addr1 = {w_iss_c, 1'b0};
            w_addr2 = {w_iss_c, 1'b1};
        end else begin
            w_addr1 = insert_zero_bit(w_iss_c, 3'(4'd7 - w_iss_stage));
            w_addr2 = w_addr1 + 8'(w_stride >> 2);
        end
    end

    fft_twiddle_gen u_twiddle_gen (
        .c       (w_iss_c),
        .stage   (w_iss_stage),
        .offsets (w_tw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_stage  <= 4'd0;
            r_c      <= 7'd0;
            r_drain  <= 4'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
            r_addr1  <= 8'd0;
            r_addr2  <= 8'd0;
            r_stride <= 10'd0;
            r_tw     <= '0;
        end else begin
            r_valid  <= w_emit;
            r_addr1  <= w_emit ? w_addr1  : 8'd0;
            r_addr2  <= w_emit ? w_addr2  : 8'd0;
            r_stride <= w_emit ? w_stride : 10'd0;
            r_tw     <= w_emit ? w_tw     : '0;
            r_done   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        r_state <= ST_ISSUE;
                        r_stage <= 4'd0;
                        r_c     <= 7'd1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (!bus.i_stall) begin
                        if (r_c == c_last_issue) begin
                            r_state <= ST_DRAIN;
                            r_drain <= 4'd0;
                        end else begin
                            r_c <= r_c + 7'd1;
                        end
                    end
                end
                // Stays here from the cycle showing the last issue through the drain window.
                ST_DRAIN: begin
                    if (r_drain == c_drain_last) begin
                        if (r_stage == c_last_stage) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_ISSUE;
                            r_stage <= r_stage + 4'd1;
                            r_c     <= 7'd1;
                        end
                    end else begin
                        r_drain <= r_drain + 4'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy            = r_busy;
    assign bus.o_done            = r_done;
    assign bus.o_stage           = r_stage;
    assign bus.o_valid           = r_valid;
    assign bus.o_addr1           = r_addr1;
    assign bus.o_addr2           = r_addr2;
    assign bus.o_stride          = r_stride;
    assign bus.o_twiddle_offset1 = r_tw[0];
    assign bus.o_twiddle_offset2 = r_tw[1];
    assign bus.o_twiddle_offset3 = r_tw[2];
    assign bus.o_twiddle_offset4 = r_tw[3];

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fft_stage_sequencer                                               |
// | Cycle-accurate checks of the sequencer against a schedule model.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fft_stage_sequencer;

    localparam int MAXC = 2200;

    typedef struct packed {
        logic            busy;
        logic            done;
        logic            valid;
        logic [3:0]      stage;
        logic [7:0]      a1;
        logic [7:0]      a2;
        logic [9:0]      stride;
        logic [3:0][8:0] tw;
    } out_t;

    typedef struct {
        int stage;
        int c;
        int a1;
        int a2;
        int stride;
        int tw0;
        int tw1;
        int tw2;
        int tw3;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    out_t exp_q [MAXC];
    out_t obs_q [MAXC];
    bit   stall_v [MAXC];
    bit   start_v [MAXC];
    bit   rst_v [MAXC];

    fft_stage_sequencer_if bus ();

    fft_stage_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic out_t sample();
        out_t s;
        s.busy   = bus.o_busy;
        s.done   = bus.o_done;
        s.valid  = bus.o_valid;
        s.stage  = bus.o_stage;
        s.a1     = bus.o_addr1;
        s.a2     = bus.o_addr2;
        s.stride = bus.o_stride;
        s.tw     = {bus.o_twiddle_offset4, bus.o_twiddle_offset3,
                    bus.o_twiddle_offset2, bus.o_twiddle_offset1};
        return s;
    endfunction

    function automatic out_t idle_rec(input int k, input bit busy);
        out_t r;
        r       = '0;
        r.stage = 4'(k);
        r.busy  = busy;
        return r;
    endfunction

    // Issue contents straight from the butterfly geometry of stage k.
    function automatic out_t issue_rec(input int k, input int c);
        out_t r;
        int stride, sw, a1, a2, n;
        int t [4];
        stride = 512 >> k;
        n = 0;
        if (stride >= 4) begin
            sw = stride / 4;
            a1 = (c / sw) * 2 * sw + (c % sw);
            a2 = a1 + sw;
            for (int l = 0; l < 4; l++) t[l] = 4 * a1 + l;
        end else begin
            a1 = 2 * c;
            a2 = 2 * c + 1;
            for (int s = 8 * c; s < 8 * c + 8; s++) begin
                if ((s % (2 * stride)) < stride && n < 4) begin
                    t[n] = s;
                    n++;
                end
            end
        end
        r        = '0;
        r.busy   = 1'b1;
        r.valid  = 1'b1;
        r.stage  = 4'(k);
        r.a1     = 8'(a1);
        r.a2     = 8'(a2);
        r.stride = 10'(stride);
        for (int l = 0; l < 4; l++) r.tw[l] = 9'(((t[l] % stride) * (512 / stride)) % 512);
        return r;
    endfunction

    // Expected per-cycle outputs for a run started in cycle 0; returns the o_done cycle.
    function automatic int build_exp();
        int t, dc;
        for (int i = 0; i < MAXC; i++) exp_q[i] = '0;
        t = 1;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < 128; c++) begin
                if (c > 0) begin
                    while (t < MAXC - 1 && stall_v[t-1]) begin
                        exp_q[t] = idle_rec(k, 1'b1);
                        t++;
                    end
                end
                if (t < MAXC) exp_q[t] = issue_rec(k, c);
                t++;
            end
            for (int d = 0; d < 6; d++) begin
                if (t < MAXC) exp_q[t] = idle_rec(k, 1'b1);
                t++;
            end
        end
        dc = t;
        if (t < MAXC) begin
            exp_q[t]      = idle_rec(9, 1'b1);
            exp_q[t].done = 1'b1;
        end
        for (int i = t + 1; i < MAXC; i++) exp_q[i] = idle_rec(9, 1'b0);
        for (int r = 0; r < MAXC; r++) begin
            if (rst_v[r]) begin
                for (int i = r + 1; i < MAXC; i++) exp_q[i] = '0;
                break;
            end
        end
        return dc;
    endfunction

    task automatic clear_vectors();
        for (int i = 0; i < MAXC; i++) begin
            stall_v[i] = 1'b0;
            start_v[i] = 1'b0;
            rst_v[i]   = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_stall = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_seq(input int n, input string name);
        for (int t = 0; t < n; t++) begin
            rst         = rst_v[t];
            bus.i_start = start_v[t];
            bus.i_stall = stall_v[t];
            @(negedge clk);
            obs_q[t] = sample();
            check($sformatf("%s cycle %0d", name, t), 128'(obs_q[t]), 128'(exp_q[t]));
            @(posedge clk);
            #1;
        end
        rst         = 1'b0;
        bus.i_start = 1'b0;
        bus.i_stall = 1'b0;
    endtask

    function automatic int find_done(input int n);
        for (int t = 0; t < n; t++) if (obs_q[t].done) return t;
        return -1;
    endfunction

    initial begin
        vec_t vecs [7];
        int   dc, n, cnt, dcnt;
        bit   ok;
        int   seen [256];
        out_t got;

        vecs[0] = '{0,  0,   0, 128, 512,   0,   1,   2,   3};
        vecs[1] = '{0,  5,   5, 133, 512,  20,  21,  22,  23};
        vecs[2] = '{1, 100, 164, 228, 256, 288, 290, 292, 294};
        vecs[3] = '{2, 40,  72, 104, 128, 128, 132, 136, 140};
        vecs[4] = '{7, 10,  20,  21,   4,   0, 128, 256, 384};
        vecs[5] = '{8,  3,   6,   7,   2,   0, 256,   0, 256};
        vecs[6] = '{9, 77, 154, 155,   1,   0,   0,   0,   0};

        bus.i_start = 1'b0;
        bus.i_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        check("reset_state", 128'(sample()), 128'(0));
        @(posedge clk);
        #1;

        // Run A: clean run with a stray start while busy.
        clear_vectors();
        start_v[0]   = 1'b1;
        start_v[200] = 1'b1;
        dc = build_exp();
        n  = dc + 4;
        run_seq(n, "runA");
        check("runA done_cycle", 128'(find_done(n)), 128'(1341));
        cnt = 0;
        dcnt = 0;
        for (int t = 0; t < n; t++) begin
            if (obs_q[t].valid) cnt++;
            if (obs_q[t].done) dcnt++;
        end
        check("runA valid_count", 128'(cnt), 128'(1280));
        check("runA done_count", 128'(dcnt), 128'(1));
        for (int k = 0; k < 10; k++) begin
            for (int w = 0; w < 256; w++) seen[w] = 0;
            for (int t = 1 + 134 * k; t <= 128 + 134 * k; t++) begin
                if (obs_q[t].valid) begin
                    seen[obs_q[t].a1]++;
                    seen[obs_q[t].a2]++;
                end
            end
            ok = 1'b1;
            for (int w = 0; w < 256; w++) if (seen[w] != 1) ok = 1'b0;
            check($sformatf("runA word_cover stage %0d", k), 128'(ok), 128'(1));
        end
        for (int i = 0; i < 7; i++) begin
            got = obs_q[1 + 134 * vecs[i].stage + vecs[i].c];
            check($sformatf("vector stage %0d c %0d", vecs[i].stage, vecs[i].c),
                  {got.valid, got.stage, got.a1, got.a2, got.stride, got.tw},
                  {1'b1, 4'(vecs[i].stage), 8'(vecs[i].a1), 8'(vecs[i].a2), 10'(vecs[i].stride),
                   9'(vecs[i].tw3), 9'(vecs[i].tw2), 9'(vecs[i].tw1), 9'(vecs[i].tw0)});
        end

        // Run B: three stall cycles aimed at stage 1, c=50.
        do_reset();
        clear_vectors();
        start_v[0] = 1'b1;
        for (int t = 184; t <= 186; t++) stall_v[t] = 1'b1;
        dc = build_exp();
        n  = dc + 4;
        run_seq(n, "runB");
        check("runB done_cycle", 128'(find_done(n)), 128'(1344));
        check("runB stall_gap", 128'({obs_q[185].valid, obs_q[186].valid, obs_q[187].valid}), 128'(0));
        check("runB reissue c50", 128'(obs_q[188]), 128'(issue_rec(1, 50)));

        // Run C: random stalls.
        do_reset();
        clear_vectors();
        start_v[0] = 1'b1;
        for (int t = 1; t < MAXC; t++) stall_v[t] = ($urandom_range(0, 9) == 0);
        dc = build_exp();
        n  = (dc + 4 < MAXC) ? dc + 4 : MAXC;
        run_seq(n, "runC");
        check("runC done_seen", 128'(find_done(n) == dc), 128'(1));

        // Run D: reset mid-run, colliding with a start in the same cycle.
        do_reset();
        clear_vectors();
        start_v[0]   = 1'b1;
        rst_v[400]   = 1'b1;
        start_v[400] = 1'b1;
        dc = build_exp();
        run_seq(1500, "runD");
        check("runD outputs_after_rst", 128'(obs_q[401]), 128'(0));
        check("runD no_done", 128'(find_done(1500)), 128'(-1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
